uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter between command_manager replies and an auto-stream of
//  R-peak sample numbers popped from the dout FIFO. Serialises each FIFO entry into an atomic
//  byte frame, paces bytes against tx_busy, and round-robins the two requesters at frame
//  granularity. Sits between command_manager/dout FIFO and uart on the 100 MHz domain.
// PARAMETERS
//  CTR_WIDTH     32     width of FIFO entry (R-peak sample number); NB = ceil(CTR_WIDTH/8)
//  FRAME_HDR     8'hA5  first byte of every stream frame
//  BUSY_TIMEOUT  1023   max cycles to wait for tx_busy to rise after a byte pulse
// PORTS
//  i_clk            in   1          system clock (single clock domain)
//  i_rst            in   1          synchronous reset, active-high
//  i_cmd_tx_data    in   8          reply byte from command_manager
//  i_cmd_tx_valid   in   1          1-cycle pulse, reply byte present
//  o_cmd_overrun    out  1          1-cycle pulse: reply byte arrived while holding reg full
//  i_stream_en      in   1          enable auto-streaming of FIFO entries
//  i_fifo_empty     in   1          dout FIFO empty
//  o_fifo_pop       out  1          1-cycle pop request to dout FIFO
//  i_fifo_rdata     in   CTR_WIDTH  FIFO read data
//  i_fifo_rvalid    in   1          i_fifo_rdata valid (1 cycle, >=1 cycle after pop)
//  o_tx_data        out  8          byte to uart
//  o_tx_data_valid  out  1          1-cycle start pulse to uart
//  i_tx_busy        in   1          uart transmitting
//  o_tx_timeout     out  1          1-cycle pulse: busy never rose within BUSY_TIMEOUT
//  o_stream_active  out  1          high while a stream frame is in progress
//  o_frame_cnt      out  16         stream frames completed, wraps 16'hFFFF->0
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, holding reg empty, rr pointer = CMD, frame_cnt 0.
//  - Cmd holding reg (1 entry): captures i_cmd_tx_data on i_cmd_tx_valid in any state. If full,
//    new byte dropped, o_cmd_overrun pulses. Cleared in the cycle its byte is issued; capture
//    and clear in the same cycle -> new byte kept, no overrun.
//  - Stream request = i_stream_en & !i_fifo_empty. Cmd request = holding reg full.
//  - Arbitration only in IDLE; both requesting -> grant side != last granted (round-robin);
//    one requesting -> grant it. Frames never interrupted.
//  - FSM: IDLE -> FETCH (stream: o_fifo_pop 1 cycle, wait i_fifo_rvalid, latch data)
//    -> SEND (o_tx_data_valid=1 one cycle, o_tx_data driven) -> WAIT_HI (until i_tx_busy=1)
//    -> WAIT_LO (until i_tx_busy=0) -> next byte SEND or IDLE. Cmd grant: IDLE->SEND directly.
//  - Stream frame: FRAME_HDR, then NB data bytes MSB first (zero-padded to 8*NB bits).
//  - o_tx_data holds last issued byte between pulses. Min 1 idle cycle between frames.
//  - WAIT_HI counter > BUSY_TIMEOUT -> o_tx_timeout pulse, byte treated as sent, continue.
//  - o_stream_active 1 from FETCH entry to end of last WAIT_LO of stream frame.
//  - o_frame_cnt increments on completion of last byte of a stream frame.
//  - i_stream_en falling mid-frame: frame completes; no further pops.
//  - Reset mid-frame: abort immediately, popped entry discarded, no partial recovery.
// CONFIGURATION
//  RPEAK_STREAM_CRC_EN defined: stream frame gets one extra trailing byte = XOR of FRAME_HDR
//    and all NB data bytes (frame length NB+2). Not defined: frame = hdr + NB bytes (NB+1),
//    no checksum logic. Cmd replies unaffected either way.
// TESTING
//  1 Cmd only: pulse 8'h3C, busy model 10 cycles -> one tx pulse with 8'h3C, no fifo pop.
//  2 Stream: CTR_WIDTH=32, FIFO holds 32'h0001_2345, en=1 -> bytes A5,00,01,23,45 (+A5^00^01^23^45=C2
//    with CRC_EN), frame_cnt=1, fifo empty after.
//  3 Contention: cmd 8'h11 + 2 FIFO entries pending -> order: 8'h11, frame0, then frame1
//    (alternation when cmd re-pulsed 8'h22 mid-frame0: 8'h11, frame0, 8'h22, frame1).
//  4 Overrun: two cmd pulses during a stream frame -> first kept, o_cmd_overrun pulses once.
//  5 Timeout: hold i_tx_busy=0 -> o_tx_timeout after 1024 cycles per byte, frame still completes.
//  6 i_rst=1 mid frame (after 2nd byte) -> outputs 0 next cycle, IDLE; next frame starts with A5.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares the single UART transmitter between command_manager reply bytes
//   and an auto-stream of R-peak sample numbers popped from the dout FIFO.
//   Each FIFO entry is sent as an atomic frame: FRAME_HDR, then NB data bytes
//   MSB first (NB = ceil(CTR_WIDTH/8), zero-padded). Bytes are paced against
//   i_tx_busy and the two requesters are round-robined per frame.
//
//   Optional feature macro: RPEAK_STREAM_CRC_EN
//     defined   -> stream frames carry a trailing XOR checksum byte
//     undefined -> frame is header + NB data bytes, no checksum logic
//
// Ports
//   i_clk, i_rst                       clock, synchronous active-high reset
//   i_cmd_tx_data/i_cmd_tx_valid       reply byte strobe from command_manager
//   o_cmd_overrun                      pulse: reply dropped, holding reg full
//   i_stream_en                        enable auto-streaming of FIFO entries
//   i_fifo_empty/o_fifo_pop            dout FIFO status / pop request
//   i_fifo_rdata/i_fifo_rvalid         dout FIFO read data / valid strobe
//   o_tx_data/o_tx_data_valid          byte and start pulse to uart
//   i_tx_busy                          uart transmitting
//   o_tx_timeout                       pulse: busy never rose after a byte
//   o_stream_active                    stream frame in progress
//   o_frame_cnt                        completed stream frames (wrapping)
module uart_tx_arbiter #(
  parameter int unsigned CTR_WIDTH    = 32,
  parameter logic [7:0]  FRAME_HDR    = 8'hA5,
  parameter int unsigned BUSY_TIMEOUT = 1023
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [7:0]           i_cmd_tx_data,
  input  logic                 i_cmd_tx_valid,
  output logic                 o_cmd_overrun,
  input  logic                 i_stream_en,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_pop,
  input  logic [CTR_WIDTH-1:0] i_fifo_rdata,
  input  logic                 i_fifo_rvalid,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_data_valid,
  input  logic                 i_tx_busy,
  output logic                 o_tx_timeout,
  output logic                 o_stream_active,
  output logic [15:0]          o_frame_cnt
);

  localparam int unsigned NB = (CTR_WIDTH + 7) / 8;
  localparam int unsigned DW = 8 * NB;
`ifdef RPEAK_STREAM_CRC_EN
  localparam int unsigned LAST_IDX = NB + 1;
`else
  localparam int unsigned LAST_IDX = NB;
`endif
  localparam int unsigned IDX_W = $clog2(LAST_IDX + 1);
  localparam int unsigned CNT_W = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t             state, state_nxt;
  logic               hold_full, hold_full_nxt;
  logic [7:0]         hold_data, hold_data_nxt;
  logic               rr_stream, rr_stream_nxt;   // 1: stream has priority on contention
  logic               cur_stream, cur_stream_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;               // byte position within the frame
  logic [DW-1:0]      data_sr, data_sr_nxt;       // remaining data bytes, MSB first
  logic [CNT_W-1:0]   busy_cnt, busy_cnt_nxt;
  logic [7:0]         tx_data_nxt;
  logic               tx_valid_nxt, pop_nxt, overrun_nxt, timeout_nxt, active_nxt;
  logic [15:0]        frame_cnt_nxt;
  logic [7:0]         tx_byte;
  logic               is_hdr, is_crc, issue_cmd, stream_req, grant_stream;
`ifdef RPEAK_STREAM_CRC_EN
  logic [7:0]         crc, crc_nxt;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_nxt      = state;
    hold_full_nxt  = hold_full;
    hold_data_nxt  = hold_data;
    rr_stream_nxt  = rr_stream;
    cur_stream_nxt = cur_stream;
    idx_nxt        = idx;
    data_sr_nxt    = data_sr;
    busy_cnt_nxt   = busy_cnt;
    tx_data_nxt    = o_tx_data;
    frame_cnt_nxt  = o_frame_cnt;
    tx_valid_nxt   = 1'b0;
    pop_nxt        = 1'b0;
    overrun_nxt    = 1'b0;
    timeout_nxt    = 1'b0;
    active_nxt     = 1'b0;
    tx_byte        = 8'h00;
`ifdef RPEAK_STREAM_CRC_EN
    crc_nxt        = crc;
    is_crc         = (idx == IDX_W'(LAST_IDX));
`else
    is_crc         = 1'b0;
`endif
    is_hdr         = (idx == '0);
    stream_req     = i_stream_en & ~i_fifo_empty;
    grant_stream   = stream_req & (~hold_full | rr_stream);
    issue_cmd      = (state == SEND) & ~cur_stream;

    // Holding register: a capture in the same cycle as the clear is kept
    if (issue_cmd) hold_full_nxt = 1'b0;
    if (i_cmd_tx_valid) begin
      if (hold_full && !issue_cmd) begin
        overrun_nxt = 1'b1;
      end else begin
        hold_full_nxt = 1'b1;
        hold_data_nxt = i_cmd_tx_data;
      end
    end

    // Byte to issue in SEND
    if (!cur_stream)  tx_byte = hold_data;
    else if (is_hdr)  tx_byte = FRAME_HDR;
`ifdef RPEAK_STREAM_CRC_EN
    else if (is_crc)  tx_byte = crc;
`endif
    else              tx_byte = data_sr[DW-1 -: 8];

    case (state)
      IDLE: begin
        if (grant_stream) begin
          state_nxt      = FETCH;
          pop_nxt        = 1'b1;
          cur_stream_nxt = 1'b1;
          rr_stream_nxt  = 1'b0;
          idx_nxt        = '0;
`ifdef RPEAK_STREAM_CRC_EN
          crc_nxt        = 8'h00;
`endif
        end else if (hold_full) begin
          state_nxt      = SEND;
          cur_stream_nxt = 1'b0;
          rr_stream_nxt  = 1'b1;
          idx_nxt        = '0;
        end
      end
      FETCH: begin
        if (i_fifo_rvalid) begin
          data_sr_nxt = DW'(i_fifo_rdata);
          state_nxt   = SEND;
        end
      end
      SEND: begin
        tx_data_nxt  = tx_byte;
        tx_valid_nxt = 1'b1;
        busy_cnt_nxt = '0;
        state_nxt    = WAIT_HI;
        if (cur_stream && !is_hdr && !is_crc) data_sr_nxt = data_sr << 8;
`ifdef RPEAK_STREAM_CRC_EN
        crc_nxt = crc ^ tx_byte;
`endif
      end
      WAIT_HI: begin
        // A byte whose busy never rises is counted as sent
        if (i_tx_busy) begin
          state_nxt = WAIT_LO;
        end else if (busy_cnt == CNT_W'(BUSY_TIMEOUT)) begin
          timeout_nxt = 1'b1;
          state_nxt   = WAIT_LO;
        end else begin
          busy_cnt_nxt = busy_cnt + CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (!i_tx_busy) begin
          if (cur_stream && (idx != IDX_W'(LAST_IDX))) begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = SEND;
          end else begin
            state_nxt = IDLE;
            if (cur_stream) frame_cnt_nxt = o_frame_cnt + 16'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    active_nxt = (state_nxt != IDLE) & cur_stream_nxt;
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= IDLE;
      hold_full       <= 1'b0;
      hold_data       <= 8'h00;
      rr_stream       <= 1'b0;
      cur_stream      <= 1'b0;
      idx             <= '0;
      data_sr         <= '0;
      busy_cnt        <= '0;
      o_tx_data       <= 8'h00;
      o_tx_data_valid <= 1'b0;
      o_fifo_pop      <= 1'b0;
      o_cmd_overrun   <= 1'b0;
      o_tx_timeout    <= 1'b0;
      o_stream_active <= 1'b0;
      o_frame_cnt     <= 16'h0000;
`ifdef RPEAK_STREAM_CRC_EN
      crc             <= 8'h00;
`endif
    end else begin
      state           <= state_nxt;
      hold_full       <= hold_full_nxt;
      hold_data       <= hold_data_nxt;
      rr_stream       <= rr_stream_nxt;
      cur_stream      <= cur_stream_nxt;
      idx             <= idx_nxt;
      data_sr         <= data_sr_nxt;
      busy_cnt        <= busy_cnt_nxt;
      o_tx_data       <= tx_data_nxt;
      o_tx_data_valid <= tx_valid_nxt;
      o_fifo_pop      <= pop_nxt;
      o_cmd_overrun   <= overrun_nxt;
      o_tx_timeout    <= timeout_nxt;
      o_stream_active <= active_nxt;
      o_frame_cnt     <= frame_cnt_nxt;
`ifdef RPEAK_STREAM_CRC_EN
      crc             <= crc_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter.
// Environment models a dout FIFO (random read latency) and a uart with
// random busy timing; expected byte streams come from a frame-level model.
module tb_uart_tx_arbiter;

  localparam int NB = 4;
`ifdef RPEAK_STREAM_CRC_EN
  localparam int FLEN = NB + 2;
`else
  localparam int FLEN = NB + 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_valid = 1'b0;
  logic        cmd_overrun;
  logic        stream_en = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        fifo_pop;
  logic [31:0] fifo_rdata = 32'h0;
  logic        fifo_rvalid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_busy = 1'b0;
  logic        tx_timeout;
  logic        stream_active;
  logic [15:0] frame_cnt;

  uart_tx_arbiter #(.CTR_WIDTH(32), .FRAME_HDR(8'hA5), .BUSY_TIMEOUT(1023)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_tx_data(cmd_data), .i_cmd_tx_valid(cmd_valid), .o_cmd_overrun(cmd_overrun),
    .i_stream_en(stream_en), .i_fifo_empty(fifo_empty), .o_fifo_pop(fifo_pop),
    .i_fifo_rdata(fifo_rdata), .i_fifo_rvalid(fifo_rvalid),
    .o_tx_data(tx_data), .o_tx_data_valid(tx_data_valid), .i_tx_busy(tx_busy),
    .o_tx_timeout(tx_timeout), .o_stream_active(stream_active), .o_frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Environment state (each variable written by exactly one process)
  logic [31:0] fifo_mem [256];
  int          wr_ptr = 0, rd_ptr = 0;
  logic [31:0] pend_data = 32'h0;
  int          pop_wait = 0;
  logic [7:0]  rx_mem [512];
  int          rx_cnt = 0, pops = 0, ovr_cnt = 0, to_cnt = 0, bad_gap = 0, act_bytes = 0;
  int          cyc = 0, last_valid_cyc = 0, rise_wait = 0, busy_left = 0;
  bit          uart_on = 1'b1;

  int          n_tests = 0, n_fail = 0;
  int          rx_base = 0;
  logic [15:0] exp_fc = 16'h0;
  logic [7:0]  exp_q [$];

  // FIFO, uart and monitor models, sampled just after the clock edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      tx_busy = 1'b0; rise_wait = 0; busy_left = 0; fifo_rvalid = 1'b0; pop_wait = 0;
    end else begin
      fifo_rvalid = 1'b0;
      if (pop_wait > 0) begin
        pop_wait--;
        if (pop_wait == 0) begin fifo_rdata = pend_data; fifo_rvalid = 1'b1; end
      end
      if (fifo_pop) begin
        pops++;
        if (rd_ptr != wr_ptr) begin pend_data = fifo_mem[rd_ptr[7:0]]; rd_ptr++; end
        pop_wait = int'($urandom_range(1, 3));
      end
      if (tx_busy) begin
        if (busy_left <= 1) tx_busy = 1'b0; else busy_left--;
      end else if (rise_wait > 0) begin
        rise_wait--;
        if (rise_wait == 0) tx_busy = 1'b1;
      end
      if (tx_timeout) begin
        to_cnt++;
        if (cyc - last_valid_cyc != 1024) bad_gap++;
      end
      if (tx_data_valid) begin
        rx_mem[rx_cnt[8:0]] = tx_data;
        rx_cnt++;
        last_valid_cyc = cyc;
        if (stream_active) act_bytes++;
        if (uart_on) begin
          busy_left = int'($urandom_range(2, 6));
          rise_wait = int'($urandom_range(0, 2));
          if (rise_wait == 0) tx_busy = 1'b1;
        end
      end
      if (cmd_overrun) ovr_cnt++;
    end
    fifo_empty = (rd_ptr == wr_ptr);
  end

  // Frame-level reference: header, data bytes MSB first, optional XOR byte
  function automatic void add_frame(input logic [31:0] v);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'hA5;
    exp_q.push_back(8'hA5);
    for (int i = NB - 1; i >= 0; i--) begin
      b = v[8*i +: 8];
      exp_q.push_back(b);
      x = x ^ b;
    end
`ifdef RPEAK_STREAM_CRC_EN
    exp_q.push_back(x);
`endif
  endfunction

  task automatic push_entry(input logic [31:0] v);
    fifo_mem[wr_ptr[7:0]] = v;
    wr_ptr++;
  endtask

  task automatic pulse_cmd(input logic [7:0] b);
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Bounded wait for nbytes received and the transmitter settled
  task automatic wait_done(input int nbytes, input int max_cyc, output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if ((rx_cnt - rx_base) >= nbytes && !stream_active && !tx_busy) quiet++;
      else quiet = 0;
      if (quiet >= 4) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_active(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (stream_active) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({tx_data_valid, fifo_pop, cmd_overrun, tx_timeout, stream_active} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_pulses got %b exp 00000",
               {tx_data_valid, fifo_pop, cmd_overrun, tx_timeout, stream_active});
    end
    n_tests++;
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    n_tests++;
    if (frame_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
  endtask

  task automatic test_cmd_only();
    logic [7:0] b;
    int p0, a0;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      b = (k == 0) ? 8'h3C : 8'($urandom);
      rx_base = rx_cnt; p0 = pops; a0 = act_bytes;
      pulse_cmd(b);
      wait_done(1, 300, ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL cmd_done got timeout exp done"); end
      n_tests++;
      if (rx_cnt - rx_base != 1) begin n_fail++; $display("FAIL cmd_count got %0d exp 1", rx_cnt - rx_base); end
      n_tests++;
      if (rx_mem[rx_base[8:0]] !== b) begin
        n_fail++; $display("FAIL cmd_byte got %h exp %h", rx_mem[rx_base[8:0]], b);
      end
      n_tests++;
      if (tx_data !== b) begin n_fail++; $display("FAIL cmd_hold_data got %h exp %h", tx_data, b); end
      n_tests++;
      if (pops - p0 != 0 || act_bytes - a0 != 0) begin
        n_fail++; $display("FAIL cmd_no_stream got pops=%0d active=%0d exp 0 0", pops - p0, act_bytes - a0);
      end
    end
    n_tests++;
    if (frame_cnt !== exp_fc) begin n_fail++; $display("FAIL cmd_frame_cnt got %0d exp %0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_stream();
    logic [31:0] v;
    logic [39:0] first;
    int p0, a0, n;
    bit ok;
    exp_q.delete(); rx_base = rx_cnt; p0 = pops; a0 = act_bytes;
    push_entry(32'h0001_2345); add_frame(32'h0001_2345);
    for (int i = 0; i < 3; i++) begin v = $urandom; push_entry(v); add_frame(v); end
    n = exp_q.size();
    stream_en = 1'b1;
    wait_done(n, 3000, ok);
    stream_en = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL stream_done got timeout exp done"); end
    n_tests++;
    if (rx_cnt - rx_base != n) begin n_fail++; $display("FAIL stream_count got %0d exp %0d", rx_cnt - rx_base, n); end
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (rx_mem[9'(rx_base + i)] !== exp_q[i]) begin
        n_fail++; $display("FAIL stream_byte[%0d] got %h exp %h", i, rx_mem[9'(rx_base + i)], exp_q[i]);
      end
    end
    first = {rx_mem[9'(rx_base)], rx_mem[9'(rx_base + 1)], rx_mem[9'(rx_base + 2)],
             rx_mem[9'(rx_base + 3)], rx_mem[9'(rx_base + 4)]};
    n_tests++;
    if (first !== 40'hA5_0001_2345) begin n_fail++; $display("FAIL stream_vector got %h exp a500012345", first); end
    exp_fc = exp_fc + 16'd4;
    n_tests++;
    if (frame_cnt !== exp_fc) begin n_fail++; $display("FAIL stream_frame_cnt got %0d exp %0d", frame_cnt, exp_fc); end
    n_tests++;
    if (pops - p0 != 4) begin n_fail++; $display("FAIL stream_pops got %0d exp 4", pops - p0); end
    n_tests++;
    if (act_bytes - a0 != n) begin n_fail++; $display("FAIL stream_active got %0d exp %0d", act_bytes - a0, n); end
    n_tests++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL stream_fifo_empty got %b exp 1", fifo_empty); end
  endtask

  task automatic test_contention();
    logic [31:0] e0, e1;
    logic [7:0] a, b;
    int o0, n;
    bit ok;
    for (int k = 0; k < 3; k++) begin
      e0 = $urandom; e1 = $urandom;
      a = (k == 0) ? 8'h11 : 8'($urandom);
      b = (k == 0) ? 8'h22 : 8'($urandom);
      exp_q.delete(); rx_base = rx_cnt; o0 = ovr_cnt;
      push_entry(e0); push_entry(e1);
      exp_q.push_back(a); add_frame(e0); exp_q.push_back(b); add_frame(e1);
      n = exp_q.size();
      pulse_cmd(a);
      repeat (4) @(negedge clk);
      stream_en = 1'b1;
      pulse_cmd(b);
      wait_done(n, 3000, ok);
      stream_en = 1'b0;
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rr_done got timeout exp done"); end
      n_tests++;
      if (rx_cnt - rx_base != n) begin n_fail++; $display("FAIL rr_count got %0d exp %0d", rx_cnt - rx_base, n); end
      for (int i = 0; i < n; i++) begin
        n_tests++;
        if (rx_mem[9'(rx_base + i)] !== exp_q[i]) begin
          n_fail++; $display("FAIL rr_byte[%0d] got %h exp %h", i, rx_mem[9'(rx_base + i)], exp_q[i]);
        end
      end
      n_tests++;
      if (ovr_cnt != o0) begin n_fail++; $display("FAIL rr_overrun got %0d exp 0", ovr_cnt - o0); end
      exp_fc = exp_fc + 16'd2;
    end
    n_tests++;
    if (frame_cnt !== exp_fc) begin n_fail++; $display("FAIL rr_frame_cnt got %0d exp %0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_overrun();
    logic [31:0] e0;
    logic [7:0] c, d;
    int o0, n;
    bit ok;
    e0 = $urandom; c = 8'($urandom); d = 8'($urandom);
    exp_q.delete(); rx_base = rx_cnt; o0 = ovr_cnt;
    push_entry(e0); add_frame(e0); exp_q.push_back(c);
    n = exp_q.size();
    stream_en = 1'b1;
    wait_active(100, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ovr_start got timeout exp active"); end
    repeat (2) @(negedge clk);
    pulse_cmd(c);
    repeat (2) @(negedge clk);
    pulse_cmd(d);
    wait_done(n, 3000, ok);
    stream_en = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ovr_done got timeout exp done"); end
    n_tests++;
    if (ovr_cnt - o0 != 1) begin n_fail++; $display("FAIL ovr_pulses got %0d exp 1", ovr_cnt - o0); end
    n_tests++;
    if (rx_cnt - rx_base != n) begin n_fail++; $display("FAIL ovr_count got %0d exp %0d", rx_cnt - rx_base, n); end
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (rx_mem[9'(rx_base + i)] !== exp_q[i]) begin
        n_fail++; $display("FAIL ovr_byte[%0d] got %h exp %h", i, rx_mem[9'(rx_base + i)], exp_q[i]);
      end
    end
    exp_fc = exp_fc + 16'd1;
  endtask

  task automatic test_en_drop();
    logic [31:0] e0, e1;
    int p0;
    bit ok;
    e0 = $urandom; e1 = $urandom;
    exp_q.delete(); rx_base = rx_cnt; p0 = pops;
    push_entry(e0); push_entry(e1); add_frame(e0);
    stream_en = 1'b1;
    wait_active(100, ok);
    stream_en = 1'b0;
    wait_done(FLEN, 2000, ok);
    repeat (10) @(negedge clk);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL drop_done got timeout exp done"); end
    n_tests++;
    if (pops - p0 != 1 || fifo_empty !== 1'b0) begin
      n_fail++; $display("FAIL drop_pops got pops=%0d empty=%b exp 1 0", pops - p0, fifo_empty);
    end
    n_tests++;
    if (rx_cnt - rx_base != FLEN) begin n_fail++; $display("FAIL drop_count got %0d exp %0d", rx_cnt - rx_base, FLEN); end
    for (int i = 0; i < FLEN; i++) begin
      n_tests++;
      if (rx_mem[9'(rx_base + i)] !== exp_q[i]) begin
        n_fail++; $display("FAIL drop_byte[%0d] got %h exp %h", i, rx_mem[9'(rx_base + i)], exp_q[i]);
      end
    end
    exp_q.delete(); rx_base = rx_cnt; add_frame(e1);
    stream_en = 1'b1;
    wait_done(FLEN, 2000, ok);
    stream_en = 1'b0;
    for (int i = 0; i < FLEN; i++) begin
      n_tests++;
      if (rx_mem[9'(rx_base + i)] !== exp_q[i]) begin
        n_fail++; $display("FAIL drain_byte[%0d] got %h exp %h", i, rx_mem[9'(rx_base + i)], exp_q[i]);
      end
    end
    exp_fc = exp_fc + 16'd2;
    n_tests++;
    if (frame_cnt !== exp_fc) begin n_fail++; $display("FAIL drop_frame_cnt got %0d exp %0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_timeout();
    logic [31:0] e0;
    int t0, g0;
    bit ok;
    e0 = $urandom;
    exp_q.delete(); rx_base = rx_cnt; t0 = to_cnt; g0 = bad_gap;
    push_entry(e0); add_frame(e0);
    uart_on = 1'b0;
    stream_en = 1'b1;
    wait_done(FLEN, 8000, ok);
    stream_en = 1'b0;
    uart_on = 1'b1;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL to_done got timeout exp done"); end
    n_tests++;
    if (to_cnt - t0 != FLEN) begin n_fail++; $display("FAIL to_pulses got %0d exp %0d", to_cnt - t0, FLEN); end
    n_tests++;
    if (bad_gap != g0) begin n_fail++; $display("FAIL to_gap got %0d bad gaps exp 0", bad_gap - g0); end
    for (int i = 0; i < FLEN; i++) begin
      n_tests++;
      if (rx_mem[9'(rx_base + i)] !== exp_q[i]) begin
        n_fail++; $display("FAIL to_byte[%0d] got %h exp %h", i, rx_mem[9'(rx_base + i)], exp_q[i]);
      end
    end
    exp_fc = exp_fc + 16'd1;
    n_tests++;
    if (frame_cnt !== exp_fc) begin n_fail++; $display("FAIL to_frame_cnt got %0d exp %0d", frame_cnt, exp_fc); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e0, e1;
    bit ok;
    e0 = $urandom; e1 = $urandom;
    rx_base = rx_cnt;
    push_entry(e0); push_entry(e1);
    stream_en = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (rx_cnt - rx_base >= 2) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_start got timeout exp 2 bytes"); end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({tx_data_valid, fifo_pop, stream_active, tx_data, frame_cnt} !== 27'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs got v=%b p=%b a=%b d=%h fc=%0d exp all 0",
               tx_data_valid, fifo_pop, stream_active, tx_data, frame_cnt);
    end
    rst = 1'b0;
    exp_fc = 16'h0;
    exp_q.delete(); rx_base = rx_cnt; add_frame(e1);
    wait_done(FLEN, 2000, ok);
    stream_en = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rstmid_done got timeout exp done"); end
    for (int i = 0; i < FLEN; i++) begin
      n_tests++;
      if (rx_mem[9'(rx_base + i)] !== exp_q[i]) begin
        n_fail++; $display("FAIL rstmid_byte[%0d] got %h exp %h", i, rx_mem[9'(rx_base + i)], exp_q[i]);
      end
    end
    exp_fc = exp_fc + 16'd1;
    n_tests++;
    if (frame_cnt !== exp_fc) begin n_fail++; $display("FAIL rstmid_frame_cnt got %0d exp %0d", frame_cnt, exp_fc); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_cmd_only();
    test_stream();
    test_contention();
    test_overrun();
    test_en_drop();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
